// File: rtl/ahb_data_ram.sv
// AHB-lite data-memory slave: word array with byte lanes, programmable wait
// states and two-cycle ERROR responses for misaligned or out-of-range accesses.
module ahb_data_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBUST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [32:0] RAM_BYTES = 33'(4) << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [31:0]           mem [DEPTH];
  logic [2:0]            state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  hready_q, hready_n;
  logic [1:0]            hresp_q, hresp_n;
  logic [31:0]           hrdata_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  take;
  logic                  accept;
  logic                  req_err;
  logic [31:0]           off;
  logic [3:0]            be;
  logic                  rd_data;
  logic                  wr_data;
  logic                  unused_inputs;

  // Burst type and HTRANS[0] carry no meaning for single transfers.
  assign unused_inputs = ^{HBUST, HTRANS[0]};

  // Address-phase decode: transfer request and its error classification.
  always_comb begin
    off     = HADDR - BASE_ADDR;
    accept  = hready_q && HSEL && HTRANS[1];
    req_err = (HSIZE > 3'b010)
           || ((HSIZE == 3'b001) && HADDR[0])
           || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
           || ({1'b0, off} >= RAM_BYTES);
  end

  // Next-state, wait counter and next registered response.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_n = S_IDLE;
        if (accept) begin
          take = 1'b1;
          if (req_err) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_n = S_WAIT;
            cnt_n   = 4'(WAIT_STATES - 1);
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_n = S_DATA;
        else             cnt_n   = cnt - 4'd1;
      end
      S_ERR1:  state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
    hready_n = (state_n == S_IDLE) || (state_n == S_DATA) || (state_n == S_ERR2);
    hresp_n  = ((state_n == S_ERR1) || (state_n == S_ERR2)) ? 2'b01 : 2'b00;
  end

  // Byte enables of the latched write.
  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << lane_q;
      2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    rd_data = (state == S_DATA) && !write_q;
    wr_data = (state == S_DATA) && write_q;
  end

  // State, response and latched address-phase registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      hrdata_q <= 32'd0;
      idx_q    <= '0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hready_q <= hready_n;
      hresp_q  <= hresp_n;
      if (rd_data) hrdata_q <= mem[idx_q];
      if (take) begin
        idx_q   <= off[ADDR_WIDTH+1:2];
        lane_q  <= off[1:0];
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
      end
    end
  end

  // Array write at the DATA edge; an asserted reset abandons it.
  always_ff @(posedge clk) begin
    if (reset && wr_data) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is live in a read DATA cycle and held otherwise.
  assign HRDATA = rd_data ? mem[idx_q] : hrdata_q;
  assign HREADY = hready_q;
  assign HRESP  = hresp_q;

endmodule
